cover_toggle_sched: RTL and testbench

Sequencer that sits between a design's toggle-coverage valid vector and the coverage sink. It filters repeat hits with a sticky covered map and queues only first-time hits in a pending bitmap. It drains those hits one index per handshake, in place of firing up to WIDTH sink calls in a single cycle. It also runs a flush-then-clear sequence so the coverage map can be reset between fuzzing runs.

---
 rtl/cover_toggle_sched.sv | 147 ++++++++++++++
 tb/tb_cover_toggle_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched: filters toggle-coverage hits through a sticky covered map.
// It queues first-time hits in a pending bitmap and drains them one index per
// handshake, lowest bit first. A flush-then-clear sequence resets the map between runs.
module cover_toggle_sched #(
  parameter int          WIDTH       = 64,
  parameter int unsigned COVER_INDEX = 0,
  parameter int          IDX_W       = 64,
  parameter int          CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  valid,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [CNT_W-1:0]  covered_count,
  output logic              pending_any,
  output logic              clear_done
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_covered;
  logic [WIDTH-1:0]  r_pending;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_out_index;
  logic [CNT_W-1:0]  r_count;
  logic              r_clear_done;

  logic              w_capture;
  logic              w_wipe;
  logic [WIDTH-1:0]  w_new;
  logic              w_slot_free;
  logic [WIDTH-1:0]  w_pick_oh;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [WIDTH-1:0]  w_load_mask;

  // Number of set bits in a hit vector; one extra bit so WIDTH itself fits.
  function automatic logic [CNT_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{CNT_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Add with saturation at WIDTH, so the count stays bounded even if it is ever misused.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W:0]   add);
    logic [CNT_W+1:0] s;
    s = {2'b00, cur} + {1'b0, add};
    if (s > (CNT_W + 2)'(WIDTH)) begin
      return CNT_W'(WIDTH);
    end
    return s[CNT_W-1:0];
  endfunction

  // Lowest set pending bit: one-hot mask and its bit position.
  always_comb begin
    w_pick_oh  = '0;
    w_pick_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_pick_oh    = '0;
        w_pick_oh[i] = 1'b1;
        w_pick_idx   = IDX_W'(i);
      end
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_load_mask = w_slot_free ? w_pick_oh : '0;
  assign w_new       = w_capture ? (valid & ~r_covered) : '0;

  // Next-state and per-state controls: capture only in RUN, wipe only in CLEAR.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wipe      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_capture = enable;
        if (clear) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_pending == '0 && !r_out_valid) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_wipe      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Covered map, pending bitmap, output slot and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_covered    <= '0;
      r_pending    <= '0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
      r_count      <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_pending    <= (r_pending & ~w_load_mask) | w_new;
      r_clear_done <= w_wipe;
      if (w_wipe) begin
        r_covered <= '0;
        r_count   <= '0;
      end else begin
        r_covered <= r_covered | w_new;
        r_count   <= sat_count(r_count, popcount(w_new));
      end
      if (w_slot_free) begin
        if (r_pending != '0) begin
          r_out_valid <= 1'b1;
          r_out_index <= IDX_W'(COVER_INDEX) + w_pick_idx;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_index     = r_out_index;
  assign covered_count = r_count;
  assign pending_any   = (r_pending != '0) || r_out_valid;
  assign clear_done    = r_clear_done;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched (WIDTH=64, COVER_INDEX=100).
module tb_cover_toggle_sched;

  localparam int WIDTH = 64;
  localparam int IDX_W = 64;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [WIDTH-1:0]  valid;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_index;
  logic [CNT_W-1:0]  covered_count;
  logic              pending_any;
  logic              clear_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_emit;
  logic [IDX_W-1:0] last_idx;

  cover_toggle_sched #(
    .WIDTH(WIDTH), .COVER_INDEX(100), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_count(covered_count), .pending_any(pending_any), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    valid     = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", out_index, 64'd0);
    chk("rst_count", 64'(covered_count), 64'd0);
    chk("rst_pending_any", 64'(pending_any), 64'd0);
    chk("rst_clear_done", 64'(clear_done), 64'd0);

    // Single hit: bit 0 -> index 100, two edges after capture, for one cycle.
    valid = 64'h1;
    step();
    valid = '0;
    chk("single_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_index", out_index, 64'd100);
    step();
    chk("single_gone", 64'(out_valid), 64'd0);
    chk("single_count", 64'(covered_count), 64'd1);

    // Burst ordering: bits 0, 2, 63.
    do_reset();
    valid = 64'h8000_0000_0000_0005;
    step();
    valid = '0;
    step();
    chk("burst_idx0", out_index, 64'd100);
    step();
    chk("burst_idx1", out_index, 64'd102);
    step();
    chk("burst_idx2", out_index, 64'd163);
    chk("burst_valid2", 64'(out_valid), 64'd1);
    chk("burst_pend_hi", 64'(pending_any), 64'd1);
    step();
    chk("burst_done", 64'(out_valid), 64'd0);
    chk("burst_pend_lo", 64'(pending_any), 64'd0);
    chk("burst_count", 64'(covered_count), 64'd3);

    // Backpressure: bits 3 and 7, sink stalled for 5 cycles.
    do_reset();
    out_ready = 1'b0;
    valid = 64'h88;
    step();
    valid = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_index", out_index, 64'd103);
      step();
    end
    out_ready = 1'b1;
    chk("bp_first", out_index, 64'd103);
    step();
    chk("bp_second", out_index, 64'd107);
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Repeat filter: bit 4 hit on four separate cycles.
    do_reset();
    n_emit   = 0;
    last_idx = '0;
    for (int k = 0; k < 4; k++) begin
      valid = 64'h10;
      step();
      if (out_valid) begin n_emit++; last_idx = out_index; end
      valid = '0;
      for (int j = 0; j < 2; j++) begin
        step();
        if (out_valid) begin n_emit++; last_idx = out_index; end
      end
    end
    chk("repeat_emits", 64'(n_emit), 64'd1);
    chk("repeat_index", last_idx, 64'd104);
    chk("repeat_count", 64'(covered_count), 64'd1);

    // Clear sequence: bits 1 and 2 pending, FLUSH-time hits ignored.
    do_reset();
    out_ready = 1'b0;
    valid = 64'h6;
    step();
    valid = '0;
    clear = 1'b1;
    step();
    clear     = 1'b0;
    valid     = 64'hFF;
    out_ready = 1'b1;
    chk("clr_idx1", out_index, 64'd101);
    chk("clr_valid1", 64'(out_valid), 64'd1);
    step();
    chk("clr_idx2", out_index, 64'd102);
    step();
    chk("clr_drained", 64'(out_valid), 64'd0);
    chk("clr_pend_lo", 64'(pending_any), 64'd0);
    chk("clr_count_flush", 64'(covered_count), 64'd2);
    step();
    chk("clr_done_early", 64'(clear_done), 64'd0);
    step();
    chk("clr_done_pulse", 64'(clear_done), 64'd1);
    chk("clr_count_zero", 64'(covered_count), 64'd0);
    valid = '0;
    step();
    chk("clr_done_once", 64'(clear_done), 64'd0);
    chk("clr_ff_ignored", 64'(out_valid), 64'd0);
    valid = 64'h2;
    step();
    valid = '0;
    step();
    chk("clr_rehit_valid", 64'(out_valid), 64'd1);
    chk("clr_rehit_index", out_index, 64'd101);
    chk("clr_rehit_count", 64'(covered_count), 64'd1);

    // Async reset mid-drain with 10 hits pending.
    do_reset();
    out_ready = 1'b0;
    valid = 64'h3FF;
    step();
    valid = '0;
    step();
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    chk("ar_pre_count", 64'(covered_count), 64'd10);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_index", out_index, 64'd0);
    chk("ar_pending_any", 64'(pending_any), 64'd0);
    chk("ar_count", 64'(covered_count), 64'd0);
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    n_emit    = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid) n_emit++;
    end
    chk("ar_no_output", 64'(n_emit), 64'd0);
    valid = 64'h20;
    step();
    valid = '0;
    step();
    chk("ar_new_index", out_index, 64'd105);
    chk("ar_new_valid", 64'(out_valid), 64'd1);

    // Enable low: hits ignored.
    step();
    enable = 1'b0;
    valid  = 64'h40;
    step();
    valid = '0;
    step();
    chk("en_off_valid", 64'(out_valid), 64'd0);
    chk("en_off_count", 64'(covered_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
